// File: rtl/quad_updown_decoder.sv
// x4 quadrature decoder driving a wrapping up/down position counter.
// Phases pass through a reset synchroniser; decode starts only after the chain has settled.
module quad_updown_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             ovf,
    output logic             unf,
    output logic             err,
    output logic             err_sticky
);
    localparam int WARM = SYNC_STAGES + 1;
    localparam int WW   = $clog2(WARM + 1);

    logic [1:0]       s;
    logic [1:0]       prev_reg;
    logic [WW-1:0]    warm_reg, warm_next;
    logic             decode_en;
    logic             is_up, is_dn, is_err;

    logic [WIDTH-1:0] count_reg, count_next;
    logic             dir_reg, dir_next;
    logic             step_reg, step_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             err_reg, err_next;
    logic             sticky_reg, sticky_next;

    // Each stage carries both phases {A,B} together.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [1:0] ab_reg;
            logic [1:0] ab_prior;
            if (gi == 0) begin : g_first
                assign ab_prior = {a_in, b_in};
            end else begin : g_rest
                assign ab_prior = g_sync[gi-1].ab_reg;
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    ab_reg <= 2'b00;
                end else begin
                    ab_reg <= ab_prior;
                end
            end
        end
    endgenerate

    assign s = g_sync[SYNC_STAGES-1].ab_reg;

    assign decode_en = (warm_reg == WW'(WARM));
    assign warm_next = decode_en ? warm_reg : warm_reg + WW'(1);

    // Up order 00->10->11->01->00: the up successor of {A,B} is {~B,A}.
    always_comb begin
        is_up  = 1'b0;
        is_dn  = 1'b0;
        is_err = 1'b0;
        if (s != prev_reg) begin
            if ((s ^ prev_reg) == 2'b11) begin
                is_err = 1'b1;
            end else if (s == {~prev_reg[0], prev_reg[1]}) begin
                is_up = 1'b1;
            end else begin
                is_dn = 1'b1;
            end
        end
    end

    always_comb begin
        count_next  = count_reg;
        dir_next    = dir_reg;
        sticky_next = sticky_reg;
        step_next   = 1'b0;
        ovf_next    = 1'b0;
        unf_next    = 1'b0;
        err_next    = 1'b0;
        if (clear) begin
            count_next  = '0;
            sticky_next = 1'b0;
        end else if (load) begin
            count_next = load_val;
        end else if (decode_en) begin
            if (is_up) begin
                count_next = count_reg + WIDTH'(1);
                dir_next   = 1'b1;
                step_next  = 1'b1;
                ovf_next   = &count_reg;
            end else if (is_dn) begin
                count_next = count_reg - WIDTH'(1);
                dir_next   = 1'b0;
                step_next  = 1'b1;
                unf_next   = ~|count_reg;
            end else if (is_err) begin
                err_next    = 1'b1;
                sticky_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg   <= 2'b00;
            warm_reg   <= '0;
            count_reg  <= '0;
            dir_reg    <= 1'b0;
            step_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
            err_reg    <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            prev_reg   <= s;
            warm_reg   <= warm_next;
            count_reg  <= count_next;
            dir_reg    <= dir_next;
            step_reg   <= step_next;
            ovf_reg    <= ovf_next;
            unf_reg    <= unf_next;
            err_reg    <= err_next;
            sticky_reg <= sticky_next;
        end
    end

    assign count      = count_reg;
    assign dir        = dir_reg;
    assign step       = step_reg;
    assign ovf        = ovf_reg;
    assign unf        = unf_reg;
    assign err        = err_reg;
    assign err_sticky = sticky_reg;
endmodule

// File: tb/tb_quad_updown_decoder.sv
// Self-checking bench for quad_updown_decoder: a vector table run through a scoreboard queue,
// plus hand-timed sequences for latency, load collision, mid-run reset and back-to-back steps.
`timescale 1ns/1ps
module tb_quad_updown_decoder;
    localparam int WIDTH       = 4;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_in = 1'b0;
    logic             b_in = 1'b0;
    logic             clear = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] count;
    logic             dir, step, ovf, unf, err, err_sticky;

    quad_updown_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .clear(clear), .load(load), .load_val(load_val),
        .count(count), .dir(dir), .step(step), .ovf(ovf), .unf(unf),
        .err(err), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_step = 0, n_ovf = 0, n_unf = 0, n_err = 0;
    int step_run = 0, max_run = 0;

    // Pulse monitor samples just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (step === 1'b1) begin
            n_step++;
            step_run++;
        end else begin
            step_run = 0;
        end
        if (step_run > max_run) max_run = step_run;
        if (ovf === 1'b1) n_ovf++;
        if (unf === 1'b1) n_unf++;
        if (err === 1'b1) n_err++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic [1:0] ab;
        logic       clr;
        logic       ld;
        logic [3:0] ldv;
        int         hold;
        logic [3:0] exp_count;
        logic       exp_dir;
        logic       exp_stk;
        int         exp_step;
        int         exp_ovf;
        int         exp_unf;
        int         exp_err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, expv);
        end
    endtask

    task automatic add(input string name, input logic [1:0] ab, input logic clr, input logic ld,
                       input logic [3:0] ldv, input int hold, input logic [3:0] cnt,
                       input logic d, input logic stk, input int st, input int ov,
                       input int un, input int er);
        vec_t v;
        v.name = name; v.ab = ab; v.clr = clr; v.ld = ld; v.ldv = ldv; v.hold = hold;
        v.exp_count = cnt; v.exp_dir = d; v.exp_stk = stk;
        v.exp_step = st; v.exp_ovf = ov; v.exp_unf = un; v.exp_err = er;
        vecs.push_back(v);
    endtask

    // Entered at a falling edge; returns at a falling edge.
    task automatic run_vec(input vec_t v);
        int s0, o0, u0, e0;
        vec_t e;
        s0 = n_step; o0 = n_ovf; u0 = n_unf; e0 = n_err;
        a_in = v.ab[1]; b_in = v.ab[0];
        clear = v.clr; load = v.ld; load_val = v.ldv;
        exp_q.push_back(v);
        repeat (v.hold) @(posedge clk);
        @(negedge clk);
        clear = 1'b0; load = 1'b0;
        e = exp_q.pop_front();
        chk({e.name, ".count"}, 32'(count), 32'(e.exp_count));
        chk({e.name, ".dir"}, 32'(dir), 32'(e.exp_dir));
        chk({e.name, ".err_sticky"}, 32'(err_sticky), 32'(e.exp_stk));
        chk({e.name, ".steps"}, n_step - s0, e.exp_step);
        chk({e.name, ".ovfs"}, n_ovf - o0, e.exp_ovf);
        chk({e.name, ".unfs"}, n_unf - u0, e.exp_unf);
        chk({e.name, ".errs"}, n_err - e0, e.exp_err);
        $display("vec %-8s ab=%b clr=%0d ld=%0d -> count=%0d dir=%0d stk=%0d steps=%0d",
                 e.name, e.ab, e.clr, e.ld, count, dir, err_sticky, n_step - s0);
    endtask

    task automatic edge_n();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [1:0] up_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int end_a, end_b;

    initial begin
        int vi, s0;
        // Section A: five full up cycles, then clear.
        for (int i = 0; i < 20; i++)
            add($sformatf("up%0d", i), up_seq[(i + 1) % 4], 1'b0, 1'b0, 4'd0, 4,
                4'((i + 1) % 16), 1'b1, 1'b0, 1, (i == 15) ? 1 : 0, 0, 0);
        add("clear", 2'b00, 1'b1, 1'b0, 4'd0, 2, 4'd0, 1'b1, 1'b0, 0, 0, 0, 0);
        end_a = vecs.size();
        // Section B: illegal transitions, a down step, clear, one up step.
        add("err_a", 2'b10, 1'b0, 1'b0, 4'd0, 4, 4'd15, 1'b0, 1'b1, 0, 0, 0, 1);
        add("down",  2'b00, 1'b0, 1'b0, 4'd0, 4, 4'd14, 1'b0, 1'b1, 1, 0, 0, 0);
        add("err_b", 2'b11, 1'b0, 1'b0, 4'd0, 4, 4'd14, 1'b0, 1'b1, 0, 0, 0, 1);
        add("clr2",  2'b11, 1'b1, 1'b0, 4'd0, 2, 4'd0,  1'b0, 1'b0, 0, 0, 0, 0);
        add("up_a",  2'b01, 1'b0, 1'b0, 4'd0, 4, 4'd1,  1'b1, 1'b0, 1, 0, 0, 0);
        end_b = vecs.size();
        // Section C: step after the load collision, clear beats load, load 7.
        add("up_b",   2'b10, 1'b0, 1'b0, 4'd0, 4, 4'd10, 1'b1, 1'b0, 1, 0, 0, 0);
        add("clr_ld", 2'b10, 1'b1, 1'b1, 4'd5, 1, 4'd0,  1'b1, 1'b0, 0, 0, 0, 0);
        add("ld7",    2'b10, 1'b0, 1'b1, 4'd7, 1, 4'd7,  1'b1, 1'b0, 0, 0, 0, 0);

        // Reset with phases idle.
        @(negedge clk);
        repeat (3) edge_n();
        chk("rst.count", 32'(count), 0);
        chk("rst.dir", 32'(dir), 0);
        chk("rst.pulses", 32'({step, ovf, unf, err}), 0);
        chk("rst.err_sticky", 32'(err_sticky), 0);
        rst = 1'b0;
        repeat (6) edge_n();
        chk("warm0.count", 32'(count), 0);
        chk("warm0.steps", n_step, 0);
        chk("warm0.errs", n_err, 0);
        $display("reset: count=%0d steps=%0d errs=%0d", count, n_step, n_err);

        for (vi = 0; vi < end_a; vi++) run_vec(vecs[vi]);
        chk("up20.total_steps", n_step, 20);
        chk("up20.total_ovf", n_ovf, 1);

        // Down edge from 0: unf and step together on the third edge.
        s0 = n_step;
        a_in = 1'b0; b_in = 1'b1;
        edge_n();
        chk("lat1.count", 32'(count), 0);
        edge_n();
        chk("lat2.count", 32'(count), 0);
        chk("lat2.step", 32'(step), 0);
        edge_n();
        chk("lat3.count", 32'(count), 15);
        chk("lat3.step_unf_ovf_dir", 32'({step, unf, ovf, dir}), 32'(4'b1100));
        edge_n();
        chk("lat4.pulses", 32'({step, unf}), 0);
        chk("lat4.count", 32'(count), 15);
        chk("lat.steps", n_step - s0, 1);
        $display("underflow: count=%0d dir=%0d steps=%0d", count, dir, n_step - s0);

        for (vi = end_a; vi < end_b; vi++) run_vec(vecs[vi]);

        // Load lands on the same edge as a decoded up step.
        s0 = n_step;
        a_in = 1'b0; b_in = 1'b0;
        edge_n();
        edge_n();
        load = 1'b1; load_val = 4'd9;
        edge_n();
        load = 1'b0;
        chk("ldcol.count", 32'(count), 9);
        chk("ldcol.step", 32'(step), 0);
        chk("ldcol.dir", 32'(dir), 1);
        repeat (3) edge_n();
        chk("ldcol.hold_count", 32'(count), 9);
        chk("ldcol.steps", n_step - s0, 0);
        $display("load collision: count=%0d steps=%0d", count, n_step - s0);

        for (vi = end_b; vi < vecs.size(); vi++) run_vec(vecs[vi]);

        // Reset on the edge where a step from 7 would land, phases left non-zero.
        a_in = 1'b1; b_in = 1'b1;
        edge_n();
        edge_n();
        rst = 1'b1;
        edge_n();
        chk("rstmid.count", 32'(count), 0);
        chk("rstmid.step_dir", 32'({step, dir}), 0);
        edge_n();
        rst = 1'b0;
        s0 = n_step;
        repeat (8) edge_n();
        chk("rstmid.warm_steps", n_step - s0, 0);
        chk("rstmid.warm_count", 32'(count), 0);
        a_in = 1'b0; b_in = 1'b1;
        repeat (4) edge_n();
        chk("rstmid.resume_count", 32'(count), 1);
        chk("rstmid.resume_dir", 32'(dir), 1);
        chk("rstmid.resume_steps", n_step - s0, 1);
        $display("mid reset: count=%0d dir=%0d steps=%0d", count, dir, n_step - s0);

        // Phase changes on four consecutive cycles give four consecutive pulses.
        s0 = n_step;
        max_run = 0;
        for (int i = 0; i < 4; i++) begin
            a_in = up_seq[i][1]; b_in = up_seq[i][0];
            edge_n();
        end
        repeat (4) edge_n();
        chk("b2b.count", 32'(count), 5);
        chk("b2b.steps", n_step - s0, 4);
        chk("b2b.run", max_run, 4);
        $display("back-to-back: count=%0d steps=%0d run=%0d", count, n_step - s0, max_run);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
